// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one bit per clock LSB first,
// with registered difference, borrow-out and signed overflow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             br, ai, bi, d, br_nx, last;

    always_comb begin
        ai    = sa[0];
        bi    = sb[0];
        d     = ai ^ bi ^ br;
        br_nx = (~ai & bi) | (~(ai ^ bi) & br);
        last  = cnt == CW'(WIDTH - 1);
    end

    assign busy = state != IDLE;
    assign done = state == DONE;

    // sa doubles as the result register: difference bits enter at the MSB
    // as minuend bits leave at the LSB, so on the last bit ai/bi are the MSBs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa    <= a;
                    sb    <= b;
                    br    <= bin;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sa  <= {d, sa[WIDTH-1:1]};
                    sb  <= sb >> 1;
                    br  <= br_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        diff  <= {d, sa[WIDTH-1:1]};
                        bout  <= br_nx;
                        ovf   <= (ai ^ bi) & (d ^ ai);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and swept checks of serial_subtractor
// at WIDTH=4, plus random operands at WIDTH=8.
module tb_serial_subtractor;
    logic clk, rst_n;
    logic start4, bin4, busy4, done4, bout4, ovf4;
    logic [3:0] a4, b4, diff4;
    logic start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;
    int checks = 0;
    int failures = 0;

    logic [3:0] va [5] = '{4'd5, 4'd3, 4'd0, 4'd8, 4'd7};
    logic [3:0] vb [5] = '{4'd3, 4'd5, 4'd0, 4'd1, 4'hF};
    logic       vi [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] vd [5] = '{4'd2, 4'hE, 4'hF, 4'd7, 4'd8};
    logic       vo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       vv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns the number of edges after the capture edge until done is seen.
    task automatic op4(input logic [3:0] av, bv, input logic bi, output int n);
        int k = 0;
        while (busy4 !== 1'b0 && k < 20) begin @(posedge clk); #1; k++; end
        a4 = av; b4 = bv; bin4 = bi; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = ~av; b4 = ~bv; bin4 = ~bi;
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    endtask

    task automatic op8(input logic [7:0] av, bv, input logic bi, output int n);
        int k = 0;
        while (busy8 !== 1'b0 && k < 20) begin @(posedge clk); #1; k++; end
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~av; b8 = ~bv; bin8 = ~bi;
        n = 0;
        while (done8 !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_reset;
        rst_n = 1'b1; start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; bin4 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy4); end
        checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done4); end
        checks++; if (diff4 !== 4'h0) begin failures++; $display("FAIL reset_diff got=%h want=0", diff4); end
        checks++; if ({bout4, ovf4} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b want=00", {bout4, ovf4}); end
        checks++; if ({busy8, done8, diff8} !== 10'h0) begin failures++; $display("FAIL reset_w8 got=%h want=0", {busy8, done8, diff8}); end
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_vectors;
        int n;
        for (int i = 0; i < 5; i++) begin
            op4(va[i], vb[i], vi[i], n);
            checks++; if (n !== 4) begin failures++; $display("FAIL vec%0d_latency got=%0d want=4", i, n); end
            checks++; if (diff4 !== vd[i]) begin failures++; $display("FAIL vec%0d_diff got=%h want=%h", i, diff4, vd[i]); end
            checks++; if ({bout4, ovf4} !== {vo[i], vv[i]}) begin failures++; $display("FAIL vec%0d_bout_ovf got=%b want=%b", i, {bout4, ovf4}, {vo[i], vv[i]}); end
            checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL vec%0d_busy_done got=%b want=1", i, busy4); end
            @(posedge clk); #1;
            checks++; if ({done4, busy4} !== 2'b00) begin failures++; $display("FAIL vec%0d_done_pulse got=%b want=00", i, {done4, busy4}); end
        end
    endtask

    task automatic test_sweep;
        int n;
        logic [4:0] r;
        logic [5:0] exp_v;
        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int bi = 0; bi < 2; bi++) begin
                    op4(4'(av), 4'(bv), 1'(bi), n);
                    r = 5'(av) - 5'(bv) - 5'(bi);
                    exp_v = {r, (4'(av) >> 3 != 4'(bv) >> 3) && (r[3] != 1'(av >> 3))};
                    checks++;
                    if ({bout4, diff4, ovf4} !== exp_v || n !== 4) begin
                        failures++;
                        $display("FAIL sweep a=%0d b=%0d bin=%0d got=%b lat=%0d want=%b lat=4", av, bv, bi, {bout4, diff4, ovf4}, n, exp_v);
                    end
                end
    endtask

    task automatic test_ignore;
        int n, pulses = 0;
        logic [3:0] dseen = 4'h0;
        logic bseen = 1'b0;
        op4(4'd5, 4'd3, 1'b0, n);
        @(posedge clk); #1;
        a4 = 4'd3; b4 = 4'd5; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        a4 = 4'd9; b4 = 4'd1; bin4 = 1'b1; start4 = 1'b1;
        checks++; if (diff4 !== 4'd2) begin failures++; $display("FAIL hold_during_shift got=%h want=2", diff4); end
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done4 === 1'b1) begin pulses++; dseen = diff4; bseen = bout4; end
            @(posedge clk); #1;
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL ignore_pulses got=%0d want=1", pulses); end
        checks++; if ({bseen, dseen} !== 5'h1E) begin failures++; $display("FAIL ignore_result got=%h want=1e", {bseen, dseen}); end
    endtask

    task automatic test_abort;
        int n, pulses = 0;
        a4 = 4'd8; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy4, done4, diff4, bout4, ovf4} !== 8'h00) begin failures++; $display("FAIL abort_async got=%h want=00", {busy4, done4, diff4, bout4, ovf4}); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done4 !== 1'b0) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", pulses); end
        @(negedge clk) rst_n = 1'b1;
        op4(4'd5, 4'd3, 1'b0, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL abort_restart_latency got=%0d want=4", n); end
        checks++; if ({bout4, diff4, ovf4} !== 6'b000100) begin failures++; $display("FAIL abort_restart_result got=%b want=000100", {bout4, diff4, ovf4}); end
    endtask

    task automatic test_back_to_back;
        int n = 0, k = 0;
        while (busy4 !== 1'b0 && k < 20) begin @(posedge clk); #1; k++; end
        a4 = 4'd5; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
        k = 0;
        while (done4 !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        do begin @(posedge clk); #1; n++; end while (done4 !== 1'b1 && n < 20);
        checks++; if (n !== 6) begin failures++; $display("FAIL b2b_period got=%0d want=6", n); end
        checks++; if (diff4 !== 4'd2) begin failures++; $display("FAIL b2b_diff got=%h want=2", diff4); end
        start4 = 1'b0;
    endtask

    task automatic test_w8;
        int n;
        logic [7:0] av, bv;
        logic bi;
        logic [8:0] r;
        logic [9:0] exp_v;
        for (int i = 0; i < 40; i++) begin
            av = 8'($urandom); bv = 8'($urandom); bi = 1'($urandom);
            if (i == 0) begin av = 8'h80; bv = 8'h01; bi = 1'b0; end
            op8(av, bv, bi, n);
            r = {1'b0, av} - {1'b0, bv} - {8'h0, bi};
            exp_v = {r, (av[7] != bv[7]) && (r[7] != av[7])};
            checks++;
            if ({bout8, diff8, ovf8} !== exp_v || n !== 8) begin
                failures++;
                $display("FAIL w8 a=%h b=%h bin=%b got=%b lat=%0d want=%b lat=8", av, bv, bi, {bout8, diff8, ovf8}, n, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_sweep();
        test_ignore();
        test_abort();
        test_back_to_back();
        test_w8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
